sar_adc_ctrl: RTL and testbench



---
 rtl/lvdt_adc_pkg.sv | 16 +
 rtl/sar_adc_ctrl_timer.sv | 29 ++
 rtl/sar_adc_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lvdt_adc_pkg.sv
// Shared definitions for the LVDT demodulator ADC path: code width, default
// conversion timing and the SAR controller state encoding.
package lvdt_adc_pkg;

    localparam int ADC_WIDTH             = 5;
    localparam int DEFAULT_SAMPLE_CYCLES = 2;
    localparam int DEFAULT_SETTLE_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        DONE
    } sar_state_t;

endpackage

// File: rtl/sar_adc_ctrl_timer.sv
// Loadable down-counter used for both the sample window and each trial's
// settle window. done marks the last cycle of the loaded window.
module sar_phase_timer #(
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic          done
);

    logic [TW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    // Saturates at zero, so an idle timer never wraps into a stale window.
    assign done = en && (count_reg == '0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: samples, walks the DAC trial code
// MSB first against the comparator, and hands the result out on valid/ready.
module sar_adc_ctrl
    import lvdt_adc_pkg::*;
#(
    parameter int WIDTH         = ADC_WIDTH,
    parameter int SAMPLE_CYCLES = DEFAULT_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample_en,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready
);

    localparam int TMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [TW-1:0]    SAMPLE_LOAD = TW'(SAMPLE_CYCLES - 1);
    localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0]    TOP_IDX     = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_ONE     = {1'b1, {(WIDTH-1){1'b0}}};

    sar_state_t state_reg, state_next;

    logic             sample_en_reg, sample_en_next;
    logic [WIDTH-1:0] dac_reg, dac_next;
    logic             busy_reg, busy_next;
    logic [WIDTH-1:0] data_out_reg, data_out_next;
    logic             valid_reg, valid_next;
    logic [IW-1:0]    bit_idx_reg, bit_idx_next;

    logic             timer_load;
    logic [TW-1:0]    timer_load_val;
    logic             timer_en;
    logic             timer_done;

    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] resolved;

    sar_phase_timer #(
        .TW(TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .en       (timer_en),
        .done     (timer_done)
    );

    // One-hot mask of the bit currently under trial.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
        assign bit_mask[gi] = (bit_idx_reg == IW'(gi));
    end

    assign resolved = cmp_in ? dac_reg : (dac_reg & ~bit_mask);
    assign timer_en = (state_reg == SAMPLE) || (state_reg == SETTLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)                              state_next = SAMPLE;
            SAMPLE:  if (timer_done)                         state_next = SETTLE;
            SETTLE:  if (timer_done && bit_idx_reg == '0)    state_next = DONE;
            DONE:    if (data_ready)                         state_next = IDLE;
            default:                                         state_next = IDLE;
        endcase
    end

    always_comb begin
        sample_en_next = sample_en_reg;
        dac_next       = dac_reg;
        data_out_next  = data_out_reg;
        valid_next     = valid_reg;
        bit_idx_next   = bit_idx_reg;
        timer_load     = 1'b0;
        timer_load_val = '0;
        case (state_reg)
            IDLE: begin
                dac_next = '0;
                if (start) begin
                    sample_en_next = 1'b1;
                    timer_load     = 1'b1;
                    timer_load_val = SAMPLE_LOAD;
                end
            end
            SAMPLE: begin
                if (timer_done) begin
                    sample_en_next = 1'b0;
                    dac_next       = MSB_ONE;
                    bit_idx_next   = TOP_IDX;
                    timer_load     = 1'b1;
                    timer_load_val = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (timer_done) begin
                    // Decide the current bit and, if any remain, try the next lower one.
                    if (bit_idx_reg != '0) begin
                        dac_next       = resolved | (bit_mask >> 1);
                        bit_idx_next   = bit_idx_reg - 1'b1;
                        timer_load     = 1'b1;
                        timer_load_val = SETTLE_LOAD;
                    end else begin
                        dac_next      = resolved;
                        data_out_next = resolved;
                        valid_next    = 1'b1;
                    end
                end
            end
            DONE: begin
                if (data_ready) begin
                    valid_next = 1'b0;
                    dac_next   = '0;
                end
            end
            default: ;
        endcase
    end

    assign busy_next = (state_next != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_en_reg <= 1'b0;
            dac_reg       <= '0;
            busy_reg      <= 1'b0;
            data_out_reg  <= '0;
            valid_reg     <= 1'b0;
            bit_idx_reg   <= TOP_IDX;
        end else begin
            sample_en_reg <= sample_en_next;
            dac_reg       <= dac_next;
            busy_reg      <= busy_next;
            data_out_reg  <= data_out_next;
            valid_reg     <= valid_next;
            bit_idx_reg   <= bit_idx_next;
        end
    end

    assign sample_en  = sample_en_reg;
    assign dac_code   = dac_reg;
    assign busy       = busy_reg;
    assign data_out   = data_out_reg;
    assign data_valid = valid_reg;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: default-timing instance plus a 1/1-cycle
// build, each driven by an ideal comparator model against a bench input code.
module tb_sar_adc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       data_ready = 1'b0;
    logic [4:0] vin_code = '0;
    logic       cmp_in;
    logic       sample_en;
    logic [4:0] dac_code;
    logic       busy;
    logic [4:0] data_out;
    logic       data_valid;

    logic       start2 = 1'b0;
    logic       data_ready2 = 1'b0;
    logic [4:0] vin2 = '0;
    logic       cmp2;
    logic       sample_en2;
    logic [4:0] dac2;
    logic       busy2;
    logic [4:0] data_out2;
    logic       data_valid2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign cmp_in = (vin_code >= dac_code);
    assign cmp2   = (vin2 >= dac2);

    sar_adc_ctrl #(.WIDTH(5), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .cmp_in(cmp_in),
        .sample_en(sample_en), .dac_code(dac_code), .busy(busy),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready)
    );

    sar_adc_ctrl #(.WIDTH(5), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(1)) dut_fast (
        .clk(clk), .rst(rst), .start(start2), .cmp_in(cmp2),
        .sample_en(sample_en2), .dac_code(dac2), .busy(busy2),
        .data_out(data_out2), .data_valid(data_valid2), .data_ready(data_ready2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if (sample_en !== 1'b0 || dac_code !== 5'd0 || busy !== 1'b0 ||
            data_out !== 5'd0 || data_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_state se=%b dac=%0d busy=%b dout=%0d valid=%b, expected all zero",
                     sample_en, dac_code, busy, data_out, data_valid);
        end
        tests++;
        if (sample_en2 !== 1'b0 || dac2 !== 5'd0 || busy2 !== 1'b0 || data_valid2 !== 1'b0) begin
            fails++;
            $display("FAIL reset_state_fast se=%b dac=%0d busy=%b valid=%b, expected all zero",
                     sample_en2, dac2, busy2, data_valid2);
        end
        rst = 1'b0;
        $display("[TB] reset released");
    endtask

    // Starts a conversion on the next edge and checks the trial sequence and
    // the 12-cycle latency. keep_start leaves start high afterwards.
    task automatic test_convert(input string name, input logic [4:0] vin,
                                input logic [4:0] t0, input logic [4:0] t1,
                                input logic [4:0] t2, input logic [4:0] t3,
                                input logic [4:0] t4, input bit keep_start);
        logic [4:0] trials [5];
        trials[0] = t0; trials[1] = t1; trials[2] = t2; trials[3] = t3; trials[4] = t4;
        vin_code = vin;
        start = 1'b1;
        tick();
        start = keep_start;
        tests++;
        if (sample_en !== 1'b1 || busy !== 1'b1 || dac_code !== 5'd0) begin
            fails++;
            $display("FAIL %s_accept se=%b busy=%b dac=%0d, expected se=1 busy=1 dac=0",
                     name, sample_en, busy, dac_code);
        end
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 2) begin
                tests++;
                if (sample_en !== 1'b0) begin
                    fails++;
                    $display("FAIL %s_sample_end se=%b, expected 0", name, sample_en);
                end
            end
            if ((c % 2) == 0 && c <= 10) begin
                tests++;
                if (dac_code !== trials[c/2-1]) begin
                    fails++;
                    $display("FAIL %s_trial%0d dac=%0d, expected %0d", name, c/2-1, dac_code, trials[c/2-1]);
                end
            end
            if (c < 12) begin
                tests++;
                if (data_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL %s_early_valid cycle %0d valid=%b, expected 0", name, c, data_valid);
                end
            end
        end
        tests++;
        if (data_valid !== 1'b1 || data_out !== vin || dac_code !== vin || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s_result valid=%b dout=%0d dac=%0d busy=%b, expected valid=1 dout=%0d dac=%0d busy=1",
                     name, data_valid, data_out, dac_code, busy, vin, vin);
        end
        $display("[TB] %s vin=%0d data_out=%0d valid=%b", name, vin, data_out, data_valid);
    endtask

    task automatic release_result(input string name);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        tests++;
        if (data_valid !== 1'b0 || dac_code !== 5'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_release valid=%b dac=%0d busy=%b, expected 0 0 0",
                     name, data_valid, dac_code, busy);
        end
        $display("[TB] %s result accepted", name);
    endtask

    task automatic test_ready_idle();
        data_ready = 1'b1;
        tick();
        tick();
        data_ready = 1'b0;
        tests++;
        if (data_valid !== 1'b0 || busy !== 1'b0 || dac_code !== 5'd0) begin
            fails++;
            $display("FAIL ready_idle valid=%b busy=%b dac=%0d, expected 0 0 0", data_valid, busy, dac_code);
        end
        $display("[TB] data_ready while idle");
    endtask

    task automatic test_hold_done();
        test_convert("hold", 5'd13, 5'd16, 5'd8, 5'd12, 5'd14, 5'd13, 1'b0);
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            tick();
            tests++;
            if (data_valid !== 1'b1 || data_out !== 5'd13 || busy !== 1'b1 ||
                dac_code !== 5'd13 || sample_en !== 1'b0) begin
                fails++;
                $display("FAIL hold_done cycle %0d valid=%b dout=%0d busy=%b dac=%0d se=%b, expected 1 13 1 13 0",
                         i, data_valid, data_out, busy, dac_code, sample_en);
            end
        end
        start = 1'b0;
        release_result("hold");
    endtask

    task automatic test_back_to_back();
        test_convert("b2b_first", 5'd5, 5'd16, 5'd8, 5'd4, 5'd6, 5'd5, 1'b1);
        vin_code = 5'd26;
        release_result("b2b_first");
        test_convert("b2b_second", 5'd26, 5'd16, 5'd24, 5'd28, 5'd26, 5'd27, 1'b1);
        release_result("b2b_second");
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        vin_code = 5'd22;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        tests++;
        if (dac_code !== 5'd20 || busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_conv_state dac=%0d busy=%b, expected 20 1", dac_code, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (sample_en !== 1'b0 || dac_code !== 5'd0 || busy !== 1'b0 || data_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset se=%b dac=%0d busy=%b valid=%b, expected all zero",
                     sample_en, dac_code, busy, data_valid);
        end
        $display("[TB] reset during conversion");
        test_convert("after_reset", 5'd22, 5'd16, 5'd24, 5'd20, 5'd22, 5'd23, 1'b0);
        release_result("after_reset");
    endtask

    task automatic test_fast_build();
        logic [4:0] trials [5];
        trials[0] = 5'd16; trials[1] = 5'd8; trials[2] = 5'd12; trials[3] = 5'd10; trials[4] = 5'd11;
        vin2 = 5'd10;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tests++;
        if (sample_en2 !== 1'b1 || busy2 !== 1'b1) begin
            fails++;
            $display("FAIL fast_accept se=%b busy=%b, expected 1 1", sample_en2, busy2);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 5) begin
                tests++;
                if (dac2 !== trials[c-1] || sample_en2 !== 1'b0 || data_valid2 !== 1'b0) begin
                    fails++;
                    $display("FAIL fast_cycle%0d dac=%0d se=%b valid=%b, expected dac=%0d se=0 valid=0",
                             c, dac2, sample_en2, data_valid2, trials[c-1]);
                end
            end
        end
        tests++;
        if (data_valid2 !== 1'b1 || data_out2 !== 5'd10) begin
            fails++;
            $display("FAIL fast_result valid=%b dout=%0d, expected 1 10", data_valid2, data_out2);
        end
        $display("[TB] fast vin=10 data_out=%0d valid=%b", data_out2, data_valid2);
        data_ready2 = 1'b1;
        tick();
        data_ready2 = 1'b0;
        tests++;
        if (data_valid2 !== 1'b0 || busy2 !== 1'b0) begin
            fails++;
            $display("FAIL fast_release valid=%b busy=%b, expected 0 0", data_valid2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_ready_idle();
        test_convert("vin19", 5'd19, 5'd16, 5'd24, 5'd20, 5'd18, 5'd19, 1'b0);
        release_result("vin19");
        test_convert("vin0", 5'd0, 5'd16, 5'd8, 5'd4, 5'd2, 5'd1, 1'b0);
        release_result("vin0");
        test_convert("vin31", 5'd31, 5'd16, 5'd24, 5'd28, 5'd30, 5'd31, 1'b0);
        release_result("vin31");
        test_hold_done();
        test_back_to_back();
        test_reset_mid();
        test_fast_build();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
